// File: rtl/case_5_div_pkg.sv
// Shared types and helpers for the case_5 sequential signed divider.
// Default widths, the FSM state encoding and the sign fixup helpers live here.
package case_5_div_pkg;

    localparam int DIN0_W    = 10;
    localparam int DIN1_W    = 8;
    localparam int DIV_CNT_W = $clog2(DIN0_W);

    localparam logic [DIN0_W-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Two's-complement conditional negate; also yields |v| when neg is the sign bit.
    function automatic logic [DIN0_W-1:0] cneg0(input logic [DIN0_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIN1_W-1:0] cneg1(input logic [DIN1_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/case_5_sdiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Config: none.
module case_5_sdiv_step #(
    parameter int W = 8
) (
    input  logic [W:0]   prem_in,
    input  logic [W-1:0] dvs,
    input  logic         bit_in,
    output logic [W:0]   prem_out,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // One extra bit of headroom so the borrow shows up as the MSB of diff.
    assign shifted  = {prem_in, bit_in};
    assign diff     = shifted - {2'b00, dvs};
    assign q_bit    = ~diff[W+1];
    assign prem_out = q_bit ? diff[W:0] : shifted[W:0];

endmodule

// File: rtl/case_5_sdiv_10s_8s_10_seq.sv
// Multi-cycle signed divider (10s / 8s), truncating toward zero, ap_start/ap_done handshake.
// Latency: ap_done din0_WIDTH+1 cycles after acceptance; 1 cycle for a zero divisor with CASE_5_SDIV_ZERO_FAST_EN.
// Backpressure: ap_start ignored outside IDLE; ap_ready pulses only on the accepting cycle.
module case_5_sdiv_10s_8s_10_seq
    import case_5_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DIN0_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(din0_WIDTH - 1);

    div_state_t            state;
    logic [DIV_CNT_W-1:0]  cnt;
    logic [din0_WIDTH-1:0] dvd;
    logic [din1_WIDTH-1:0] dvs;
    logic [din1_WIDTH:0]   prem;
    logic                  sign_q;
    logic                  sign_r;
    logic                  zero;

    logic [din1_WIDTH:0]   step_rem;
    logic                  step_q;
    logic [din0_WIDTH-1:0] din0_mag;
    logic [din1_WIDTH-1:0] din1_mag;
    logic [din0_WIDTH-1:0] q_mag;

    assign din0_mag = cneg0(din0, din0[din0_WIDTH-1]);
    assign din1_mag = cneg1(din1, din1[din1_WIDTH-1]);
    // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
    assign q_mag    = {dvd[din0_WIDTH-2:0], step_q};

    case_5_sdiv_step #(.W(din1_WIDTH)) u_step (
        .prem_in  (prem),
        .dvs      (dvs),
        .bit_in   (dvd[din0_WIDTH-1]),
        .prem_out (step_rem),
        .q_bit    (step_q)
    );

    assign ap_idle  = (state == IDLE);
    assign ap_done  = (state == DONE);
    assign ap_ready = ap_idle & ap_start;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        dvd    <= din0_mag;
                        dvs    <= din1_mag;
                        sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        sign_r <= din0[din0_WIDTH-1];
                        zero   <= (din1 == '0);
                        prem   <= '0;
                        cnt    <= CNT_LOAD;
`ifdef CASE_5_SDIV_ZERO_FAST_EN
                        if (din1 == '0) begin
                            dout        <= DIV_ZERO_QUOT;
                            rem         <= '0;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    prem <= step_rem;
                    dvd  <= q_mag;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        if (zero) begin
                            dout        <= DIV_ZERO_QUOT;
                            rem         <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            dout        <= cneg0(q_mag, sign_q);
                            rem         <= cneg1(step_rem[din1_WIDTH-1:0], sign_r);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_5_sdiv_10s_8s_10_seq.sv
// Directed bench for the case_5 sequential signed divider: arithmetic matrix, latency,
// back-to-back handshake and asynchronous mid-operation reset.
module tb_case_5_sdiv_10s_8s_10_seq;

    logic       ap_clk;
    logic       ap_rst;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_idle;
    logic       ap_done;
    logic [9:0] din0;
    logic [7:0] din1;
    logic [9:0] dout;
    logic [7:0] rem;
    logic       div_by_zero;

    int checks = 0;
    int passed = 0;

    logic [9:0] last_q;
    logic [7:0] last_r;
    logic       last_z;

    case_5_sdiv_10s_8s_10_seq #(
        .ID(1), .din0_WIDTH(10), .din1_WIDTH(8), .dout_WIDTH(10)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .din0        (din0),
        .din1        (din1),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run_op(input string tag, input int d0, input int d1,
                          input logic [9:0] eq, input logic [7:0] er, input logic ez,
                          input int elat);
        int lat;
        bit idle_bad;
        din0     = 10'(d0);
        din1     = 8'(d1);
        ap_start = 1'b1;
        #1;
        chk({tag, "_ready"}, ap_ready, 1);
        tick();
        ap_start = 1'b0;
        lat      = 1;
        idle_bad = 1'b0;
        while (ap_done !== 1'b1 && lat < 30) begin
            if (ap_idle !== 1'b0) idle_bad = 1'b1;
            tick();
            lat++;
        end
        if (ap_idle !== 1'b0) idle_bad = 1'b1;
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_idle_low"}, idle_bad, 0);
        chk({tag, "_dout"}, dout, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        tick();
        chk({tag, "_done_pulse"}, ap_done, 0);
        chk({tag, "_dout_hold"}, dout, eq);
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    int  t_d0 [3] = '{200, -77, 511};
    int  t_d1 [3] = '{9, 6, -3};
    logic [9:0] t_q [3] = '{10'd22, 10'h3F4, 10'h356};
    logic [7:0] t_r [3] = '{8'd2, 8'hFB, 8'd1};

    initial begin
        int  zlat;
        bit  seen;
        logic [9:0] hq;
        logic [7:0] hr;

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_idle", ap_idle, 1);
        tick();
        tick();
        ap_rst = 1'b0;
        tick();

        run_op("p100_7",   100,   7, 10'd14,  8'd2,   1'b0, 11);
        run_op("m100_7",  -100,   7, 10'h3F2, 8'hFE,  1'b0, 11);
        run_op("p100_m7",  100,  -7, 10'h3F2, 8'd2,   1'b0, 11);
        run_op("m100_m7", -100,  -7, 10'd14,  8'hFE,  1'b0, 11);
        run_op("p300_m128", 300, -128, 10'h3FE, 8'd44, 1'b0, 11);
        run_op("ovf_m1",  -512,  -1, 10'h200, 8'd0,   1'b0, 11);
        run_op("ovf_p1",  -512,   1, 10'h200, 8'd0,   1'b0, 11);
`ifdef CASE_5_SDIV_ZERO_FAST_EN
        zlat = 1;
`else
        zlat = 11;
`endif
        run_op("div0",      37,   0, 10'h3FF, 8'd0,   1'b1, zlat);
        run_op("after_div0", 100, 7, 10'd14,  8'd2,   1'b0, 11);

        // ap_start held high with operands changing every cycle.
        hq = last_q;
        hr = last_r;
        for (int c = 0; c < 36; c++) begin
            if (c % 12 == 0) begin
                din0 = 10'(t_d0[c / 12]);
                din1 = 8'(t_d1[c / 12]);
            end else begin
                din0 = 10'(c * 37 + 5);
                din1 = 8'(c + 2);
            end
            ap_start = 1'b1;
            #1;
            chk($sformatf("b2b_ready_c%0d", c), ap_ready, (c % 12 == 0) ? 1 : 0);
            if (c % 12 == 11) begin
                chk($sformatf("b2b_done_c%0d", c), ap_done, 1);
                chk($sformatf("b2b_dout_c%0d", c), dout, t_q[c / 12]);
                chk($sformatf("b2b_rem_c%0d", c), rem, t_r[c / 12]);
                hq = t_q[c / 12];
                hr = t_r[c / 12];
            end else begin
                chk($sformatf("b2b_nodone_c%0d", c), ap_done, 0);
                chk($sformatf("b2b_hold_c%0d", c), {dout, rem}, {hq, hr});
            end
            tick();
        end
        ap_start = 1'b0;
        tick();
        chk("b2b_final_idle", ap_idle, 1);

        // Asynchronous reset during CALC cycle 5.
        din0     = 10'd123;
        din1     = 8'd4;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (4) tick();
        #3;
        ap_rst = 1'b1;
        #1;
        chk("mrst_dout", dout, 0);
        chk("mrst_rem", rem, 0);
        chk("mrst_dbz", div_by_zero, 0);
        chk("mrst_idle", ap_idle, 1);
        chk("mrst_done", ap_done, 0);
        tick();
        ap_rst = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            tick();
            if (ap_done !== 1'b0) seen = 1'b1;
        end
        chk("mrst_no_done", seen, 0);
        run_op("post_rst", 50, 5, 10'd10, 8'd0, 1'b0, 11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
